// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM encoding and
// counter width.
package sw_debounce_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_e;

    typedef logic [CNT_W-1:0] db_cnt_t;

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: two-flop synchronizer, STABLE/COUNT FSM with a
// saturating-by-construction counter, registered edge pulses and sticky flag.
module sw_db_chan
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic sw_raw,
    input  logic evt_clr,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_evt
);

    localparam db_cnt_t CNT_LAST = db_cnt_t'(DB_CYCLES - 1);

    logic      s1;
    logic      s2;
    db_state_e state;
    db_cnt_t   cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            state    <= ST_STABLE;
            cnt      <= '0;
            sw_clean <= 1'b0;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
            sw_evt   <= 1'b0;
        end else begin
            s1      <= sw_raw;
            s2      <= s1;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            if (evt_clr) begin
                sw_evt <= 1'b0;
            end

            // NOTE: with non-blocking assignments the last one in the block
            // wins, so an accepted change below overrides a same-cycle clear.
            case (state)
                ST_STABLE: begin
                    if (s2 != sw_clean) begin
                        state <= ST_COUNT;
                        cnt   <= db_cnt_t'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_COUNT: begin
                    if (s2 == sw_clean) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        sw_clean <= s2;
                        sw_rise  <= s2;
                        sw_fall  <= ~s2;
                        sw_evt   <= 1'b1;
                        state    <= ST_STABLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer; each bit of sw_raw is handled by its own
// fully independent sw_db_chan instance.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW      = 2,
    parameter int DB_CYCLES = 50000
) (
    input  logic            PCLK,
    input  logic            PRESERN,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_SW-1:0] evt_clr,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] sw_evt
);

    for (genvar i = 0; i < N_SW; i++) begin : g_chan
        sw_db_chan #(
            .DB_CYCLES (DB_CYCLES)
        ) u_chan (
            .PCLK     (PCLK),
            .PRESERN  (PRESERN),
            .sw_raw   (sw_raw[i]),
            .evt_clr  (evt_clr[i]),
            .sw_clean (sw_clean[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i]),
            .sw_evt   (sw_evt[i])
        );
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter N_SW, default 2, number of switch channels (matches SWCON width).
REQ-002 SHALL have parameter DB_CYCLES, default 50000, consecutive stable cycles required to accept a new level; legal range 2..65535.
REQ-003 SHALL have port PCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port PRESERN  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sw_raw  input  N_SW  asynchronous mechanical switch inputs.
REQ-006 SHALL have port evt_clr  input  N_SW  per-channel clear of sticky event flags, one-cycle pulse.
REQ-007 SHALL have port sw_clean  output  N_SW  debounced level, fed to the switch register's sw_port.
REQ-008 SHALL have port sw_rise  output  N_SW  one-cycle pulse on accepted 0->1.
REQ-009 SHALL have port sw_fall  output  N_SW  one-cycle pulse on accepted 1->0.
REQ-010 SHALL have port sw_evt  output  N_SW  sticky flag, set on any accepted change.

Function
REQ-011 SHALL pass each sw_raw bit through a two-flop synchronizer (s1, s2); only s2 is used downstream.
REQ-012 SHALL run an independent two-state FSM per channel: STABLE, COUNT, each channel with a 16-bit counter.
REQ-013 STABLE: if s2 != sw_clean, go to COUNT with cnt=1; else stay, cnt=0.
REQ-014 COUNT: if s2 == sw_clean, go to STABLE with cnt=0 (bounce rejected, no output change).
REQ-015 COUNT: if s2 != sw_clean and cnt == DB_CYCLES-1, set sw_clean=s2 and go to STABLE with cnt=0.
REQ-016 COUNT: otherwise cnt increments by 1; cnt never exceeds DB_CYCLES-1 and never wraps.
REQ-017 Latency: with sw_raw held, sw_clean SHALL change on the (DB_CYCLES+2)th rising edge counting the edge that first loads the new level into s1.
REQ-018 sw_rise/sw_fall SHALL be registered and assert in the same cycle that sw_clean takes its new value, for exactly one cycle.
REQ-019 sw_evt[i] SHALL set on an accepted change and clear on evt_clr[i]; simultaneous set and clear SHALL leave it set.
REQ-020 evt_clr SHALL NOT affect sw_clean, the FSMs, or the counters.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be handled per REQ-013..019.
REQ-022 A raw glitch shorter than DB_CYCLES cycles (as seen at s2) SHALL produce no change on any output.

Reset
REQ-023 While PRESERN=0 at a rising edge: s1, s2, sw_clean, sw_rise, sw_fall, sw_evt SHALL become 0, all FSMs STABLE, all cnt 0.
REQ-024 Reset asserted mid-COUNT SHALL abort the count; no rise/fall pulse is emitted for it.
REQ-025 After reset release, a switch held at 1 SHALL be accepted per REQ-017 and produce sw_rise plus sw_evt.

Structure
REQ-026 The FSM state encoding (STABLE=0, COUNT=1) and counter width constant (16) SHALL live in the shared project package/include.
REQ-027 The per-channel synchronizer+FSM+counter SHALL be a sub-module sw_db_chan, instantiated N_SW times by generate.
REQ-028 Target 120-400 RTL lines total; no combinational path from sw_raw to any output.

Verification (benches use DB_CYCLES=4, N_SW=2)
REQ-029 Reset, sw_raw=00 -> all outputs 0; raise sw_raw[0] and hold -> sw_clean[0]=1 and sw_rise[0]=1 for one cycle exactly 6 edges after the load edge, sw_evt[0]=1.
REQ-030 sw_raw[1] toggles 1,0,1,0 every 2 cycles then rests 0 -> sw_clean[1], sw_rise[1], sw_evt[1] stay 0 throughout.
REQ-031 sw_clean=01, drop sw_raw[0] and hold -> sw_fall[0] one-cycle pulse, sw_clean=00; evt_clr=01 asserted on that same edge -> sw_evt[0] remains 1; next evt_clr=01 -> sw_evt[0]=0.
REQ-032 Both raw bits rise on the same edge -> sw_clean=11 and sw_rise=11 on the same cycle.
REQ-033 PRESERN=0 for 1 cycle while channel 0 cnt=2 -> all outputs 0, no pulse; sw_raw still 1 -> rise accepted 6 edges after release.
